// File: rtl/jtframe_ram_pkg.sv
// Shared definitions for the jtframe dual-port RAM family.
// Collision policy, legal read latencies and byte-mask helper.
package jtframe_ram_pkg;

  localparam bit P0_WINS   = 1'b1;
  localparam int RDLAT_MIN = 1;
  localparam int RDLAT_MAX = 2;
  localparam int MAX_NB    = 32;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  function automatic logic [8*MAX_NB-1:0] be_mask(
    input logic [MAX_NB-1:0] be
  );
    logic [8*MAX_NB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/jtframe_ram_clr_fsm.sv
// Clear engine: walks every address once, driving port 1's
// write path with the fill word while busy is high.
module jtframe_ram_clr_fsm
  import jtframe_ram_pkg::*;
#(
  parameter int AW         = 10,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] clr_addr
);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Next state: a clr during a sweep rewrites address 0 immediately
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_addr = cnt_q;
    busy     = 1'b0;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr) begin
          state_d = CLR_SWEEP;
          cnt_d   = '0;
        end
      end
      CLR_SWEEP: begin
        busy = 1'b1;
        if (clr) clr_addr = '0;
        cnt_d = clr_addr + 1'b1;
        if (!clr && (&cnt_q)) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // State and address counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_ON_RST ? CLR_SWEEP : CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/jtframe_dual_ram_clr.sv
// Single-clock true dual-port RAM with byte enables, 1/2-cycle
// read latency, port-0-wins collisions and a built-in clear sweep.
module jtframe_dual_ram_clr
  import jtframe_ram_pkg::*;
#(
  parameter int            DW         = 16,
  parameter int            AW         = 10,
  parameter int            RDLAT      = 1,
  parameter logic [DW-1:0] CLR_VAL    = '0,
  parameter bit            CLR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen0,
  input  logic [AW-1:0]   addr0,
  input  logic [DW-1:0]   data0,
  input  logic [DW/8-1:0] we0,
  output logic [DW-1:0]   q0,
  input  logic            cen1,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   data1,
  input  logic [DW/8-1:0] we1,
  output logic [DW-1:0]   q1,
  input  logic            clr,
  output logic            busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  if ((DW % 8) != 0 || RDLAT < RDLAT_MIN || RDLAT > RDLAT_MAX)
  begin : g_bad_param
    $error("jtframe_dual_ram_clr: DW must be n*8, RDLAT 1 or 2");
  end

  logic [AW-1:0] clr_addr;
  logic [AW-1:0] a1;
  logic [DW-1:0] d1;
  logic [NB-1:0] we0_eff, we1_eff;
  logic [DW-1:0] m0, m1;
  logic [DW-1:0] rd0_w, rd1_w;
  logic [DW-1:0] s1_0_q, s1_0_d, s2_0_q, s2_0_d;
  logic [DW-1:0] s1_1_q, s1_1_d, s2_1_q, s2_1_d;

  jtframe_ram_clr_fsm #(
    .AW         (AW),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr)
  );

  // Port 1 write path is taken over by the sweep; port 0 is gated
  always_comb begin
    we0_eff = '0;
    we1_eff = '0;
    a1      = addr1;
    d1      = data1;
    if (cen0 && !busy) we0_eff = we0;
    if (busy) begin
      a1      = clr_addr;
      d1      = CLR_VAL;
      we1_eff = '1;
    end else if (cen1) begin
      we1_eff = we1;
    end
    m0 = DW'(be_mask(MAX_NB'(we0_eff)));
    m1 = DW'(be_mask(MAX_NB'(we1_eff)));
  end

  for (genvar n = 0; n < NB; n++) begin : g_lane
    (* ramstyle = "no_rw_check" *)
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    // Port 1 first, port 0 second: port 0 wins a shared lane
    always_ff @(posedge clk) begin
      if (&m1[8*n +: 8]) mem[a1]    <= d1[8*n +: 8];
      if (&m0[8*n +: 8]) mem[addr0] <= data0[8*n +: 8];
    end

    assign rd0_w[8*n +: 8] = mem[addr0];
    assign rd1_w[8*n +: 8] = mem[addr1];
  end

  // Read pipelines: port 1 is frozen while the sweep runs
  always_comb begin
    s1_0_d = s1_0_q;
    s2_0_d = s2_0_q;
    s1_1_d = s1_1_q;
    s2_1_d = s2_1_q;
    if (cen0) begin
      s1_0_d = rd0_w;
      s2_0_d = s1_0_q;
    end
    if (cen1 && !busy) begin
      s1_1_d = rd1_w;
      s2_1_d = s1_1_q;
    end
  end

  // Read pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_0_q <= '0;
      s2_0_q <= '0;
      s1_1_q <= '0;
      s2_1_q <= '0;
    end else begin
      s1_0_q <= s1_0_d;
      s2_0_q <= s2_0_d;
      s1_1_q <= s1_1_d;
      s2_1_q <= s2_1_d;
    end
  end

  assign q0 = (RDLAT == 2) ? s2_0_q : s1_0_q;
  assign q1 = (RDLAT == 2) ? s2_1_q : s1_1_q;

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Directed bench for jtframe_dual_ram_clr (AW=4, DW=16).
// Table of port vectors plus hand sequences for clear sweeps.
module tb_jtframe_dual_ram_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen0, cen1, clr;
  logic [3:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic [1:0]  we0, we1;
  logic [15:0] q0a, q1a, q0b, q1b;
  logic        busya, busyb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtframe_dual_ram_clr #(
    .DW(16), .AW(4), .RDLAT(1), .CLR_VAL(16'h0000), .CLR_ON_RST(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(q0a),
    .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(q1a),
    .clr(clr), .busy(busya)
  );

  jtframe_dual_ram_clr #(
    .DW(16), .AW(4), .RDLAT(2), .CLR_VAL(16'h0000), .CLR_ON_RST(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cen0(cen0), .addr0(addr0), .data0(data0), .we0(we0), .q0(q0b),
    .cen1(cen1), .addr1(addr1), .data1(data1), .we1(we1), .q1(q1b),
    .clr(clr), .busy(busyb)
  );

  typedef struct {
    logic        c0;
    logic [3:0]  a0;
    logic [15:0] d0;
    logic [1:0]  w0;
    logic        c1;
    logic [3:0]  a1;
    logic [15:0] d1;
    logic [1:0]  w1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tv[17];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle;
    cen0 = 0; cen1 = 0; clr = 0;
    we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0;
    data0 = 0; data1 = 0;
  endtask

  // Count edges until busy drops on both latencies, bounded
  task automatic count_busy(input string nm, input int exp);
    int n;
    n = 0;
    while (busya && n < 100) begin
      tick;
      n++;
    end
    chk(nm, 16'(n), 16'(exp));
    chk({nm, "_b"}, {15'd0, busyb}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [3:0] chka [6];

    tv[0]  = '{1, 3, 16'hABCD, 2'b11, 1, 3, 16'h0000, 2'b00,
               16'h0000, 16'h0000};
    tv[1]  = '{1, 3, 16'h1200, 2'b10, 1, 3, 16'h0000, 2'b00,
               16'hABCD, 16'hABCD};
    tv[2]  = '{1, 3, 16'h0000, 2'b00, 1, 3, 16'h0000, 2'b00,
               16'h12CD, 16'h12CD};
    tv[3]  = '{1, 5, 16'h1111, 2'b01, 1, 5, 16'h2222, 2'b11,
               16'h0000, 16'h0000};
    tv[4]  = '{1, 5, 16'h0000, 2'b00, 1, 5, 16'h0000, 2'b00,
               16'h2211, 16'h2211};
    tv[5]  = '{1, 7, 16'h0001, 2'b11, 1, 0, 16'h0000, 2'b00,
               16'h0000, 16'h0000};
    tv[6]  = '{1, 7, 16'h0002, 2'b11, 1, 7, 16'h0000, 2'b00,
               16'h0001, 16'h0001};
    tv[7]  = '{1, 7, 16'h0000, 2'b00, 1, 7, 16'h0000, 2'b00,
               16'h0002, 16'h0002};
    tv[8]  = '{0, 0, 16'h0000, 2'b00, 1, 9, 16'hBEEF, 2'b11,
               16'h0002, 16'h0000};
    tv[9]  = '{0, 0, 16'h0000, 2'b00, 0, 3, 16'h5555, 2'b11,
               16'h0002, 16'h0000};
    tv[10] = '{0, 0, 16'h0000, 2'b00, 0, 5, 16'h6666, 2'b11,
               16'h0002, 16'h0000};
    tv[11] = '{0, 0, 16'h0000, 2'b00, 0, 7, 16'h7777, 2'b11,
               16'h0002, 16'h0000};
    tv[12] = '{1, 3, 16'h0000, 2'b00, 1, 5, 16'h0000, 2'b00,
               16'h12CD, 16'h2211};
    tv[13] = '{1, 9, 16'h0000, 2'b00, 1, 7, 16'h0000, 2'b00,
               16'hBEEF, 16'h0002};
    tv[14] = '{1, 10, 16'h3344, 2'b10, 1, 10, 16'h5566, 2'b11,
               16'h0000, 16'h0000};
    tv[15] = '{1, 11, 16'h00AA, 2'b01, 1, 11, 16'hBB00, 2'b10,
               16'h0000, 16'h0000};
    tv[16] = '{1, 10, 16'h0000, 2'b00, 1, 11, 16'h0000, 2'b00,
               16'h3366, 16'hBBAA};

    idle();
    rst = 1;
    tick;
    tick;
    chk("rst_q0", q0a, 16'h0000);
    chk("rst_q1", q1a, 16'h0000);
    chk("rst_busy", {15'd0, busya}, 16'd1);
    rst = 0;
    count_busy("rst_sweep_len", 16);

    for (int i = 0; i < 16; i++) begin
      cen0 = 1;
      addr0 = 4'(i);
      tick;
      chk($sformatf("clr_rd%0d", i), q0a, 16'h0000);
    end
    idle();

    for (int i = 0; i < 17; i++) begin
      cen0 = tv[i].c0; addr0 = tv[i].a0;
      data0 = tv[i].d0; we0 = tv[i].w0;
      cen1 = tv[i].c1; addr1 = tv[i].a1;
      data1 = tv[i].d1; we1 = tv[i].w1;
      tick;
      chk($sformatf("vec%0d_q0", i), q0a, tv[i].e0);
      chk($sformatf("vec%0d_q1", i), q1a, tv[i].e1);
    end
    idle();

    cen0 = 1;
    addr0 = 3;
    tick;
    chk("lat1_q0", q0a, 16'h12CD);
    chk("lat2_q0_e1", q0b, 16'h3366);
    addr0 = 9;
    tick;
    chk("lat1_q0_next", q0a, 16'hBEEF);
    chk("lat2_q0_e2", q0b, 16'h12CD);
    idle();

    clr = 1;
    tick;
    clr = 0;
    chk("clr_busy", {15'd0, busya}, 16'd1);
    n = 0;
    while (busya && n < 100) begin
      clr = (n == 9);
      cen1 = 1;
      addr1 = 4'(n);
      if (n == 20) begin
        cen0 = 1; addr0 = 0; data0 = 16'hFFFF; we0 = 2'b11;
      end else begin
        cen0 = 0; we0 = 0;
      end
      tick;
      n++;
    end
    idle();
    chk("restart_len", 16'(n), 16'd25);
    chk("q1_frozen", q1a, 16'hBBAA);

    chka = '{4'd3, 4'd5, 4'd9, 4'd10, 4'd11, 4'd0};
    for (int i = 0; i < 6; i++) begin
      cen0 = 1;
      addr0 = chka[i];
      tick;
      chk($sformatf("swept%0d", chka[i]), q0a, 16'h0000);
    end
    cen1 = 1;
    addr1 = 7;
    tick;
    chk("swept_p1", q1a, 16'h0000);
    idle();

    clr = 1;
    tick;
    clr = 0;
    tick;
    tick;
    tick;
    rst = 1;
    #1;
    chk("midrst_busy", {15'd0, busya}, 16'd1);
    chk("midrst_q0", q0a, 16'h0000);
    tick;
    rst = 0;
    count_busy("midrst_len", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtframe_dual_ram_clr.md
Name: jtframe_dual_ram_clr

Overview:
Single-clock, true dual-port RAM and the next generation of the team's generic dual-port RAM. It adds per-byte write enables, a selectable read latency, a defined write-collision policy, and a built-in clear engine. The clear engine fills the whole array with a constant after reset or on request. Cores use it for sprite/palette/object RAMs that must start from a known state on real hardware without relying on synthesis-time init files.

Parameters:
- DW, 16, data width; must be a multiple of 8. Local NB = DW/8 byte lanes.
- AW, 10, address width; depth 2**AW.
- RDLAT, 1, read latency in cycles; only 1 or 2 are legal (elaboration error otherwise).
- CLR_VAL, 0, DW-bit fill word written by the clear engine.
- CLR_ON_RST, 1, 1 = start a clear sweep automatically when rst deasserts.

Ports:
- clk  in  1  single clock for both ports
- rst  in  1  asynchronous, active-high reset
- cen0  in  1  port 0 clock enable
- addr0  in  AW  port 0 address
- data0  in  DW  port 0 write data
- we0  in  NB  port 0 byte write enables (bit n -> data0[8n+7:8n])
- q0  out  DW  port 0 read data
- cen1  in  1  port 1 clock enable
- addr1  in  AW  port 1 address
- data1  in  DW  port 1 write data
- we1  in  NB  port 1 byte write enables
- q1  out  DW  port 1 read data
- clr  in  1  single-cycle clear request
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (async):
  - q0, q1 and the RDLAT=2 pipeline registers go to 0.
  - Clear counter goes to 0.
  - busy goes to CLR_ON_RST.
  - Memory contents are not touched by rst.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP on clr=1 (counter <= 0).
  - SWEEP writes CLR_VAL to mem[counter] on every clk edge, ignoring cen0/cen1, then increments the counter.
  - SWEEP -> IDLE on the edge that writes address 2**AW-1.
  - busy is high for exactly 2**AW cycles, and drops on that final edge.
  - clr during SWEEP restarts the sweep at address 0.
  - rst mid-sweep aborts; the sweep restarts only if CLR_ON_RST=1.
- During busy:
  - All host writes (we0, we1) are discarded.
  - Port 0 reads continue normally.
  - Port 1's read path is frozen: q1 holds its value.
- Read: read-before-write on both ports.
  - With cenX=1 at edge k, the stage-1 register captures mem[addrX] as it was before edge k.
  - RDLAT=1: qX = stage 1, valid after edge k.
  - RDLAT=2: stage 2 captures stage 1 on the next edge where cenX=1; qX = stage 2.
  - With cenX=0 all port-X registers hold.
- Write: on an edge with cenX=1 and not busy, each byte lane n with weX[n]=1 updates mem[addrX] lane n. Other lanes are unchanged.
- Collision: both ports write the same address on the same edge.
  - Lanes enabled on only one port take that port's data.
  - Lanes enabled on both ports take port 0's data.
  - Result is deterministic; both ports are implemented in one always block on clk (port 1 assignment first, port 0 second).
- Cross-port read of an address the other port writes on the same edge returns old data.
- Synthesis: inferable block RAM with byte enables (ramstyle no_rw_check). The clear engine muxes onto port 1's address/data/we path only, so the array stays a two-port structure.
- Simulation: memory initialised to 0 at time zero so the first sweep is observable as a no-op.

Decomposition:
- Shared package jtframe_ram_pkg holds:
  - collision-policy constants (P0_WINS);
  - legal RDLAT values;
  - a function that expands an NB-bit byte enable into a DW-bit mask.
- One natural sub-module: jtframe_ram_clr_fsm. It contains the counter, busy, and the port 1 override mux selects. The top level holds the array and the read pipelines.

Test Plan:
1. rst pulse, CLR_ON_RST=1, AW=4 -> busy=1 for exactly 16 cycles after deassert; afterwards port 0 reads of addresses 0..15 all return CLR_VAL=0x0000.
2. Byte enables: write port0 addr 3 data 0xABCD we0=2'b11, then data 0x1200 we0=2'b10 -> read addr 3 returns 0x12CD after 1 cycle (RDLAT=1) or 2 cycles (RDLAT=2).
3. Collision: same edge, port0 addr 5 data 0x1111 we0=2'b01, port1 addr 5 data 0x2222 we1=2'b11 -> mem[5]=0x2211.
4. Read-during-write: mem[7]=0x0001; same edge, port0 writes 0x0002 to 7 and port1 reads 7 -> q1=0x0001, next read gives 0x0002.
5. clr at sweep index 9 (AW=4) -> counter restarts, busy lasts 9+16 cycles total; a port0 write issued mid-sweep is discarded and reads return CLR_VAL.
6. cen1=0 for 3 cycles with addr1 changing -> q1 constant; writes on port 1 ignored during those cycles.
